uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Parametrised, oversampling UART receiver, the successor to the fixed 8N1 single-sample receiver. It supports configurable frame format (data bits, parity, stop bits), majority-vote mid-bit sampling, and false-start rejection. It detects parity, framing, overrun and break conditions, and buffers received words in a small FIFO behind a valid/ready handshake with RTS flow control. It sits between the board RX pin and any byte consumer (command decoder, loopback, LED demo).

## Interface
- CLK_FREQ, 12000000: system clock frequency, Hz.
- BAUD_RATE, 115200: line rate, bit/s.
- OVERSAMPLE, 8: sample ticks per bit; even, 4..16.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: receive FIFO entries; power of 2, ≥2.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx  in  1  asynchronous serial input, idle high.
- data_out  out  DATA_BITS  head-of-FIFO word; 0 when valid=0.
- valid  out  1  FIFO non-empty.
- ready  in  1  consumer accepts head word when valid&ready.
- parity_err  out  1  head word had a parity mismatch; 0 when valid=0 or PARITY=0.
- frame_err  out  1  head word had a stop bit sampled low; 0 when valid=0.
- overrun  out  1  one-cycle pulse: completed word dropped because FIFO full.
- break_det  out  1  one-cycle pulse: break frame detected.
- rts  out  1  active-low request-to-send: 0 = send permitted; 1 when FIFO occupancy ≥ FIFO_DEPTH-1.
- busy  out  1  receiver FSM not in IDLE.

## Operation
- rx passes through a 2-flop synchronizer. Both flops reset to 1.
- Tick generator: DIV = (CLK_FREQ + BAUD_RATE*OVERSAMPLE/2) / (BAUD_RATE*OVERSAMPLE), rounded. A counter runs 0..DIV-1 and emits a one-cycle tick at DIV-1. DIV<2 is an elaboration error.
- The counter is reset to 0 on start-edge detection, so the bit phase aligns to the falling edge. It is free-running otherwise.
- Bit-tick counter: 0..OVERSAMPLE-1 per bit. Majority vote of the synced rx at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is final at tick OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: synced rx 1→0 edge → START.
- START: voted 1 → IDLE (false start, no flags). Voted 0 → at end of bit, DATA.
- DATA: shift LSB first, DATA_BITS bits. Then PARITY if PARITY≠0, else STOP.
- PARITY: voted bit compared to XOR of data (odd: expect ~XOR; even: expect XOR). Mismatch sets the word's parity flag.
- STOP: one or two bits. Any stop bit voted 0 sets the word's frame flag.
- Frame end is the vote of the last stop bit, not the bit end, so the receiver resyncs early on the next start.
- Break: data all 0, parity bit 0 (if present), and first stop bit 0.
  - Pulse break_det.
  - Push nothing and raise no frame_err.
  - Go to BREAK; wait for synced rx=1, then IDLE.
- Otherwise at frame end: push {frame_flag, parity_flag, data} and go to IDLE.
- Frames with frame_err are still pushed, flagged.
- FIFO: pointers of log2(FIFO_DEPTH)+1 bits; full/empty by MSB compare; wrap-around natural.
- Pop when valid&ready. Push when full and no pop → drop word, pulse overrun. Push and pop in the same cycle when full → both accepted, no overrun.

## Timing
- Reset (async assert, sync-safe deassert):
  - FSM IDLE, counters 0, FIFO empty.
  - valid=0, data_out=0, parity_err=0, frame_err=0.
  - overrun=0, break_det=0, rts=0, busy=0.
- Reset mid-frame: frame discarded, nothing pushed. Synchronizer reset to 1, so no spurious start after release.
- rx-pin-to-FSM latency: 2 cycles (synchronizer) plus 1 cycle edge detect.
- Push occurs at the clock edge after the final stop-bit vote. valid rises on that same edge (registered occupancy). There is no empty-FIFO bypass.
- data_out and the flags change only on pop or on a push into an empty FIFO. They are stable while valid&~ready.
- overrun and break_det are high exactly one clk cycle. rts updates on the same edge as the occupancy change.
- busy high from the START entry edge to the IDLE re-entry edge.

## Test plan
- Defaults (12 MHz, 115200, OVERSAMPLE 8 → DIV 13), ready=1, send 0xA5 8N1 → one valid pulse, data_out=0xA5, parity_err=0, frame_err=0.
- PARITY=2, send 0x07 with parity bit 0 → data_out=0x07, parity_err=1. Resend with parity bit 1 → parity_err=0.
- 2-cycle rx low glitch in IDLE → FSM returns to IDLE. No push, no flags; busy high ≤1 bit time.
- Stop bit forced low on 0x3C → data_out=0x3C, frame_err=1. Then rx low ≥10 bit times → break_det single pulse, nothing pushed, next byte 0x55 received correctly.
- ready=0, send 5 bytes 0x01..0x05 (FIFO_DEPTH=4):
  - rts=1 after the 3rd byte.
  - overrun pulses once, on the 5th byte.
  - Draining yields 0x01..0x04 in order, then valid=0.
- reset_n low mid-data-bit of 0xFF → no push; valid=0, busy=0 after release. Next byte 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote sampling, parity/frame/break detection and a small receive FIFO.
// Push lands one clk after the last stop-bit vote; the consumer stalls the FIFO via ready, and rts rises at DEPTH-1 words.
module uart_rx_os #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 rts,
  output logic                 busy
);

  localparam int DIV = (CLK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = DATA_BITS + 2;
  localparam int H   = OVERSAMPLE / 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  if (DIV < 2) begin : g_div_check
    $error("uart_rx_os: clock divider DIV must be at least 2");
  end

  logic                 rx_meta, rx_sync, rx_prev;
  logic [DW-1:0]        div_cnt;
  logic [OW-1:0]        os_cnt;
  logic [2:0]           state;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_flag, par_bit, frm_flag;
  logic                 samp_a, samp_b;

  logic tick, bit_end, vote_now, vote, start_edge, exp_par, last_stop, is_break, push;
  logic [EW-1:0] push_dat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_edge = (state == ST_IDLE) && rx_prev && !rx_sync;
  assign tick       = (div_cnt == DW'(DIV - 1));
  assign bit_end    = tick && (os_cnt == OW'(OVERSAMPLE - 1));
  assign vote_now   = tick && (os_cnt == OW'(H + 1));
  assign vote       = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);

  // Restarting both counters on the start edge puts every vote window mid-bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      os_cnt  <= '0;
      samp_a  <= 1'b1;
      samp_b  <= 1'b1;
    end else begin
      if (start_edge) begin
        div_cnt <= '0;
        os_cnt  <= '0;
      end else if (tick) begin
        div_cnt <= '0;
        os_cnt  <= bit_end ? '0 : os_cnt + 1'b1;
        if (os_cnt == OW'(H - 1)) samp_a <= rx_sync;
        if (os_cnt == OW'(H))     samp_b <= rx_sync;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign exp_par   = (PARITY == 1) ? ~(^shreg) : ^shreg;
  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
  assign is_break  = (state == ST_STOP) && vote_now && !stop_idx && !vote &&
                     (shreg == '0) && !par_bit;
  assign push      = (state == ST_STOP) && vote_now && last_stop && !is_break;
  assign push_dat  = {frm_flag | ~vote, par_flag, shreg};
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      par_flag  <= 1'b0;
      par_bit   <= 1'b0;
      frm_flag  <= 1'b0;
      break_det <= 1'b0;
    end else begin
      break_det <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            state    <= ST_START;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_flag <= 1'b0;
            par_bit  <= 1'b0;
            frm_flag <= 1'b0;
          end
        end
        ST_START: begin
          if (vote_now && vote) state <= ST_IDLE;
          else if (bit_end)     state <= ST_DATA;
        end
        ST_DATA: begin
          if (vote_now) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bit_idx == BW'(DATA_BITS - 1)) state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            else                               bit_idx <= bit_idx + 1'b1;
          end
        end
        ST_PARITY: begin
          if (vote_now) begin
            par_bit  <= vote;
            par_flag <= (vote != exp_par);
          end
          if (bit_end) state <= ST_STOP;
        end
        ST_STOP: begin
          // Leaving at the last vote rather than the bit end lets the next start edge be caught early.
          if (is_break) begin
            break_det <= 1'b1;
            state     <= ST_BREAK;
          end else if (push) begin
            state <= ST_IDLE;
          end else begin
            if (vote_now && !vote) frm_flag <= 1'b1;
            if (bit_end)           stop_idx <= 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_sync) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, occ;
  logic [EW-1:0] head;
  logic          empty, full, pop, wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && ready;
  assign wr_en = push && (!full || pop);
  assign occ   = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      overrun <= push && full && !pop;
    end
  end

  assign valid      = !empty;
  assign data_out   = valid ? head[DATA_BITS-1:0] : '0;
  assign parity_err = valid & head[DATA_BITS];
  assign frame_err  = valid & head[DATA_BITS+1];
  assign rts        = (occ >= (AW+1)'(FIFO_DEPTH - 1));

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8N1 default instance plus an even-parity instance.
module tb_uart_rx_os;
  localparam int BIT = 104;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx = 1'b1, rx_p = 1'b1, ready = 1'b1;

  logic [7:0] data_out, data_out_p;
  logic valid, parity_err, frame_err, overrun, break_det, rts, busy;
  logic valid_p, parity_err_p, frame_err_p, overrun_p, break_det_p, rts_p, busy_p;

  always #5 clk = ~clk;

  uart_rx_os dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .data_out(data_out), .valid(valid), .ready(ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .break_det(break_det),
    .rts(rts), .busy(busy));

  uart_rx_os #(.PARITY(2)) dut_p (
    .clk(clk), .reset_n(reset_n), .rx(rx_p), .data_out(data_out_p), .valid(valid_p), .ready(1'b1),
    .parity_err(parity_err_p), .frame_err(frame_err_p), .overrun(overrun_p), .break_det(break_det_p),
    .rts(rts_p), .busy(busy_p));

  // Monitors: log every accepted word and count pulse/busy cycles.
  logic [9:0] log_a [0:31];
  logic [9:0] log_p [0:31];
  int n_a = 0, n_p = 0, brk_cyc = 0, ovr_cyc = 0, busy_cyc = 0;

  always @(negedge clk) begin
    if (reset_n && valid && ready) begin
      log_a[n_a] = {frame_err, parity_err, data_out};
      n_a = n_a + 1;
    end
    if (reset_n && valid_p) begin
      log_p[n_p] = {frame_err_p, parity_err_p, data_out_p};
      n_p = n_p + 1;
    end
    if (break_det) brk_cyc = brk_cyc + 1;
    if (overrun)   ovr_cyc = ovr_cyc + 1;
    if (busy)      busy_cyc = busy_cyc + 1;
  end

  int n_cmp = 0, n_err = 0;
  int rd_a = 0, rd_p = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic which, input logic [9:0] exp);
    logic [9:0] got;
    got = 10'bx;
    if (!which && rd_a < n_a) begin
      got = log_a[rd_a];
      rd_a++;
    end else if (which && rd_p < n_p) begin
      got = log_p[rd_p];
      rd_p++;
    end
    check(tag, {22'd0, got}, {22'd0, exp});
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic which, input logic v);
    if (which) rx_p = v;
    else       rx = v;
    wait_cyc(BIT);
  endtask

  task automatic send(input logic which, input logic [7:0] d, input logic has_par,
                      input logic pbit, input logic stop_v);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (has_par) drive_bit(which, pbit);
    drive_bit(which, stop_v);
    if (which) rx_p = 1'b1;
    else       rx = 1'b1;
  endtask

  initial begin
    int base_b, base_o, base_busy;

    wait_cyc(5);
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_data", {24'd0, data_out}, 0);
    check("rst_perr", {31'd0, parity_err}, 0);
    check("rst_ferr", {31'd0, frame_err}, 0);
    check("rst_ovr", {31'd0, overrun}, 0);
    check("rst_brk", {31'd0, break_det}, 0);
    check("rst_rts", {31'd0, rts}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    reset_n = 1'b1;
    wait_cyc(20);

    send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_cyc(BIT);
    check("a5_count", n_a - rd_a, 1);
    check_word("a5_word", 1'b0, 10'h0A5);
    check("a5_valid_low", {31'd0, valid}, 0);

    send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_cyc(BIT);
    check_word("par_bad", 1'b1, 10'h107);
    send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_cyc(BIT);
    check_word("par_good", 1'b1, 10'h007);
    check("par_count", n_p - rd_p, 0);

    base_busy = busy_cyc;
    rx = 1'b0;
    wait_cyc(2);
    rx = 1'b1;
    wait_cyc(2 * BIT);
    check("glitch_nopush", n_a - rd_a, 0);
    check("glitch_busy_seen", {31'd0, (busy_cyc - base_busy) > 0}, 1);
    check("glitch_busy_le_bit", {31'd0, (busy_cyc - base_busy) <= BIT}, 1);
    check("glitch_idle", {31'd0, busy}, 0);

    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    wait_cyc(BIT);
    check_word("ferr_word", 1'b0, 10'h23C);

    base_b = brk_cyc;
    rx = 1'b0;
    wait_cyc(12 * BIT);
    rx = 1'b1;
    wait_cyc(2 * BIT);
    check("brk_pulse", brk_cyc - base_b, 1);
    check("brk_nopush", n_a - rd_a, 0);
    send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    wait_cyc(BIT);
    check_word("after_brk", 1'b0, 10'h055);

    ready = 1'b0;
    base_o = ovr_cyc;
    send(1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
    wait_cyc(20);
    send(1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
    wait_cyc(20);
    check("rts_at2", {31'd0, rts}, 0);
    send(1'b0, 8'h03, 1'b0, 1'b0, 1'b1);
    wait_cyc(20);
    check("rts_at3", {31'd0, rts}, 1);
    send(1'b0, 8'h04, 1'b0, 1'b0, 1'b1);
    wait_cyc(20);
    check("ovr_at4", ovr_cyc - base_o, 0);
    send(1'b0, 8'h05, 1'b0, 1'b0, 1'b1);
    wait_cyc(20);
    check("ovr_at5", ovr_cyc - base_o, 1);
    check("stall_head", {24'd0, data_out}, 32'h01);
    ready = 1'b1;
    wait_cyc(10);
    check("drain_count", n_a - rd_a, 4);
    check_word("drain_1", 1'b0, 10'h001);
    check_word("drain_2", 1'b0, 10'h002);
    check_word("drain_3", 1'b0, 10'h003);
    check_word("drain_4", 1'b0, 10'h004);
    check("drain_valid", {31'd0, valid}, 0);
    check("drain_rts", {31'd0, rts}, 0);

    rx = 1'b0;
    wait_cyc(BIT);
    rx = 1'b1;
    wait_cyc(BIT / 2);
    reset_n = 1'b0;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(10 * BIT);
    check("rstmid_valid", {31'd0, valid}, 0);
    check("rstmid_busy", {31'd0, busy}, 0);
    check("rstmid_nopush", n_a - rd_a, 0);
    send(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    wait_cyc(BIT);
    check_word("after_rst", 1'b0, 10'h081);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
